// File: rtl/memoria_ram_responder.sv
// Memory-side responder for the L1 miss/write-back path: DEPTH words at BASE_ADDR,
// 4-phase req/ack handshake with a fixed number of wait states before each response.
module memoria_ram_responder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned BASE_ADDR = 100,
    parameter int unsigned LATENCY   = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataIn,
    output logic              ack,
    output logic [DATA_W-1:0] dataOut,
    output logic              err,
    output logic              busy,
    output logic [7:0]        rd_count,
    output logic [7:0]        wr_count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned AXT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              eff_write_c;
    logic [ADDR_W-1:0] eff_addr_c;
    logic [DATA_W-1:0] eff_data_c;
    logic [AXT_W-1:0]  addr_ext_c;
    logic              in_range_c;
    logic [IDX_W-1:0]  idx_c;
    logic              fire_c;

    function automatic logic [DATA_W-1:0] init_word(input int unsigned i);
        case (i)
            0:       init_word = DATA_W'(5);
            1:       init_word = DATA_W'(3);
            2:       init_word = DATA_W'(1);
            default: init_word = '0;
        endcase
    endfunction

    // A zero-latency build responds on the sampling edge, so it decodes the live request.
    always_comb begin
        eff_write_c = lat_write;
        eff_addr_c  = lat_addr;
        eff_data_c  = lat_data;
        if (state == IDLE) begin
            eff_write_c = write;
            eff_addr_c  = address;
            eff_data_c  = dataIn;
        end
        addr_ext_c = {1'b0, eff_addr_c};
        in_range_c = (addr_ext_c >= AXT_W'(BASE_ADDR)) &&
                     (addr_ext_c <  AXT_W'(BASE_ADDR + DEPTH));
        idx_c      = IDX_W'(eff_addr_c - ADDR_W'(BASE_ADDR));
        fire_c     = ((state == IDLE) && req && (LATENCY == 0)) ||
                     ((state == WAIT) && (cnt == '0));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ack       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            dataOut   <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= init_word(i);
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_write <= write;
                        lat_addr  <= address;
                        lat_data  <= dataIn;
                        busy      <= 1'b1;
                        cnt       <= CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);
                        state     <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (!req) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase

            // Response is committed on the edge that enters RESP.
            if (fire_c) begin
                ack <= 1'b1;
                if (in_range_c) begin
                    err <= 1'b0;
                    if (eff_write_c) begin
                        mem[idx_c] <= eff_data_c;
                        if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
                    end else begin
                        dataOut <= mem[idx_c];
                        if (rd_count != 8'hFF) rd_count <= rd_count + 8'd1;
                    end
                end else begin
                    err     <= 1'b1;
                    dataOut <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_memoria_ram_responder.sv
// Directed bench: LATENCY=3 instance for handshake/memory behaviour,
// LATENCY=0 instance for single-edge response and counter saturation.
module tb_memoria_ram_responder;

    logic       clock;
    logic       a_reset_n, a_req, a_write, a_ack, a_err, a_busy;
    logic [7:0] a_address, a_dataIn, a_dataOut, a_rd_count, a_wr_count;
    logic       b_reset_n, b_req, b_write, b_ack, b_err, b_busy;
    logic [7:0] b_address, b_dataIn, b_dataOut, b_rd_count, b_wr_count;

    int vectors    = 0;
    int miscompares = 0;

    memoria_ram_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .BASE_ADDR(100), .LATENCY(3)) dut_a (
        .clock(clock), .reset_n(a_reset_n), .req(a_req), .write(a_write),
        .address(a_address), .dataIn(a_dataIn), .ack(a_ack), .dataOut(a_dataOut),
        .err(a_err), .busy(a_busy), .rd_count(a_rd_count), .wr_count(a_wr_count)
    );

    memoria_ram_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .BASE_ADDR(100), .LATENCY(0)) dut_b (
        .clock(clock), .reset_n(b_reset_n), .req(b_req), .write(b_write),
        .address(b_address), .dataIn(b_dataIn), .ack(b_ack), .dataOut(b_dataOut),
        .err(b_err), .busy(b_busy), .rd_count(b_rd_count), .wr_count(b_wr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic a_reset();
        a_req     = 1'b0;
        a_reset_n = 1'b0;
        #2;
        chk("rst_ack", a_ack, 0);
        chk("rst_busy", a_busy, 0);
        a_reset_n = 1'b1;
        tick();
    endtask

    // Raise req and wait (bounded) for ack; lat = edges until ack seen.
    task automatic a_start(input logic w, input logic [7:0] a, input logic [7:0] d, output int lat);
        a_req = 1'b1; a_write = w; a_address = a; a_dataIn = d; lat = 0;
        do begin
            tick();
            lat++;
        end while (!a_ack && lat < 20);
    endtask

    task automatic a_finish(input string tag);
        a_req = 1'b0;
        tick();
        chk({tag, "_ackdrop"}, a_ack, 0);
        chk({tag, "_errdrop"}, a_err, 0);
    endtask

    task automatic a_txn(input string tag, input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic exp_err, input logic [7:0] exp_data);
        int lat;
        a_start(w, a, d, lat);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_err"}, a_err, exp_err);
        chk({tag, "_data"}, a_dataOut, exp_data);
        a_finish(tag);
        chk({tag, "_hold"}, a_dataOut, exp_data);
    endtask

    initial begin
        int lat;
        int ack_cycles;
        int bad_lat;
        a_reset_n = 1'b1; a_req = 1'b0; a_write = 1'b0; a_address = '0; a_dataIn = '0;
        b_reset_n = 1'b1; b_req = 1'b0; b_write = 1'b0; b_address = '0; b_dataIn = '0;
        #1;
        a_reset_n = 1'b0; b_reset_n = 1'b0;
        #1;
        chk("rst_dataOut", a_dataOut, 0);
        chk("rst_err", a_err, 0);
        chk("rst_rd", a_rd_count, 0);
        chk("rst_wr", a_wr_count, 0);
        a_reset_n = 1'b1; b_reset_n = 1'b1;
        tick();

        // 1: read 100 with exact edge timing; address change in WAIT ignored
        a_req = 1'b1; a_write = 1'b0; a_address = 8'd100;
        tick();
        chk("t1_busy", a_busy, 1);
        a_address = 8'd102;
        tick(); tick();
        chk("t1_ack_e3", a_ack, 0);
        tick();
        chk("t1_ack_e4", a_ack, 1);
        chk("t1_data", a_dataOut, 8'd5);
        chk("t1_err", a_err, 0);
        chk("t1_rd", a_rd_count, 1);
        tick();
        chk("t1_ack_held", a_ack, 1);
        a_finish("t1");
        chk("t1_busy_idle", a_busy, 0);

        // 2: write then read back
        a_reset();
        a_txn("t2w", 1'b1, 8'd101, 8'hAA, 1'b0, 8'd0);
        a_txn("t2r", 1'b0, 8'd101, 8'h00, 1'b0, 8'hAA);
        chk("t2_wr", a_wr_count, 1);
        chk("t2_rd", a_rd_count, 1);
        a_txn("t2r3", 1'b0, 8'd103, 8'h00, 1'b0, 8'h00);

        // 3: out-of-range below and above
        a_reset();
        a_txn("t3r0", 1'b0, 8'd101, 8'h00, 1'b0, 8'd3);
        a_txn("t3r99", 1'b0, 8'd99, 8'h00, 1'b1, 8'd0);
        a_txn("t3w104", 1'b1, 8'd104, 8'h66, 1'b1, 8'd0);
        chk("t3_rd", a_rd_count, 1);
        chk("t3_wr", a_wr_count, 0);
        a_txn("t3r100", 1'b0, 8'd100, 8'h00, 1'b0, 8'd5);

        // 4: req dropped during WAIT still commits; ack is a one-cycle pulse
        a_reset();
        a_req = 1'b1; a_write = 1'b1; a_address = 8'd102; a_dataIn = 8'h3C;
        tick();
        a_req = 1'b0;
        ack_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_ack) ack_cycles++;
        end
        chk("t4_pulse", ack_cycles, 1);
        chk("t4_wr", a_wr_count, 1);
        a_txn("t4r", 1'b0, 8'd102, 8'h00, 1'b0, 8'h3C);

        // 5: asynchronous reset in WAIT drops the pending write
        a_reset();
        a_req = 1'b1; a_write = 1'b1; a_address = 8'd100; a_dataIn = 8'hFF;
        tick(); tick();
        chk("t5_busy_pre", a_busy, 1);
        #2;
        a_reset_n = 1'b0;
        #1;
        chk("t5_ack", a_ack, 0);
        chk("t5_busy", a_busy, 0);
        a_req = 1'b0;
        #1;
        a_reset_n = 1'b1;
        tick();
        a_txn("t5r", 1'b0, 8'd100, 8'h00, 1'b0, 8'd5);
        chk("t5_wr", a_wr_count, 0);

        // 6: zero-latency build, single-edge response and saturating read count
        b_req = 1'b1; b_write = 1'b1; b_address = 8'd103; b_dataIn = 8'h77;
        tick();
        chk("t6_wack", b_ack, 1);
        chk("t6_wr", b_wr_count, 1);
        b_req = 1'b0;
        tick();
        chk("t6_wdrop", b_ack, 0);
        bad_lat = 0;
        for (int i = 0; i < 260; i++) begin
            b_req = 1'b1; b_write = 1'b0; b_address = 8'd103;
            tick();
            if (!b_ack || b_dataOut !== 8'h77) bad_lat++;
            b_req = 1'b0;
            tick();
            if (i == 253) chk("t6_rd254", b_rd_count, 254);
            if (i == 254) chk("t6_rd255", b_rd_count, 255);
        end
        chk("t6_lat", bad_lat, 0);
        chk("t6_sat", b_rd_count, 255);
        chk("t6_wr_end", b_wr_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
